// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: NUM_BITS-wide adder split into NUM_STAGES equal chunks, one chunk added per
// pipeline stage with the carry registered in between; valid/stall handshake, per-transaction overflow mode.
module adder_pipe_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                signed_mode,
  input  logic                valid_in,
  input  logic                stall,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                valid_out
);

  localparam int CHUNK = (NUM_STAGES > 0) ? (NUM_BITS / NUM_STAGES) : 1;

  if (NUM_STAGES > NUM_BITS) begin : g_errDepth
    $error("adder_pipe_nbit: NUM_STAGES (%0d) exceeds NUM_BITS (%0d)", NUM_STAGES, NUM_BITS);
  end
  if ((NUM_STAGES > 0) && (NUM_BITS % NUM_STAGES != 0)) begin : g_errChunk
    $error("adder_pipe_nbit: NUM_BITS (%0d) is not a multiple of NUM_STAGES (%0d)", NUM_BITS, NUM_STAGES);
  end

  // Stage s holds the finished low (s+1) chunks of the sum plus only the operand bits not yet added.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int REM = NUM_BITS - s * CHUNK;

    logic [REM-1:0]         w_aIn;
    logic [REM-1:0]         w_bIn;
    logic                   w_cIn;
    logic                   w_modeIn;
    logic                   w_validIn;
    logic [CHUNK:0]         w_add;
    logic [(s+1)*CHUNK-1:0] r_sum;
    logic                   r_valid;

    if (s == 0) begin : g_src
      assign w_aIn     = a;
      assign w_bIn     = b;
      assign w_cIn     = carry_in;
      assign w_modeIn  = signed_mode;
      assign w_validIn = valid_in;
    end else begin : g_src
      assign w_aIn     = g_stage[s-1].g_fwd.r_aHi;
      assign w_bIn     = g_stage[s-1].g_fwd.r_bHi;
      assign w_cIn     = g_stage[s-1].g_fwd.r_carry;
      assign w_modeIn  = g_stage[s-1].g_fwd.r_mode;
      assign w_validIn = g_stage[s-1].r_valid;
    end

    assign w_add = {1'b0, w_aIn[CHUNK-1:0]} + {1'b0, w_bIn[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_cIn};

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_valid <= w_validIn;
      end
    end

    if (s == 0) begin : g_sum
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_sum <= '0;
        end else if (!stall) begin
          r_sum <= w_add[CHUNK-1:0];
        end
      end
    end else begin : g_sum
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_sum <= '0;
        end else if (!stall) begin
          r_sum <= {w_add[CHUNK-1:0], g_stage[s-1].r_sum};
        end
      end
    end

    if (s < NUM_STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] r_aHi;
      logic [REM-CHUNK-1:0] r_bHi;
      logic                 r_carry;
      logic                 r_mode;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_aHi   <= '0;
          r_bHi   <= '0;
          r_carry <= 1'b0;
          r_mode  <= 1'b0;
        end else if (!stall) begin
          r_aHi   <= w_aIn[REM-1:CHUNK];
          r_bHi   <= w_bIn[REM-1:CHUNK];
          r_carry <= w_add[CHUNK];
          r_mode  <= w_modeIn;
        end
      end
    end else begin : g_last
      logic w_msbCarryIn;
      logic r_ovf;

      // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
      assign w_msbCarryIn = w_add[CHUNK-1] ^ w_aIn[CHUNK-1] ^ w_bIn[CHUNK-1];

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_ovf <= 1'b0;
        end else if (!stall) begin
          r_ovf <= w_modeIn ? (w_msbCarryIn ^ w_add[CHUNK]) : w_add[CHUNK];
        end
      end
    end
  end

  assign sum       = g_stage[NUM_STAGES-1].r_sum;
  assign overflow  = g_stage[NUM_STAGES-1].g_last.r_ovf;
  assign valid_out = g_stage[NUM_STAGES-1].r_valid;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit: directed vector table and corner sequences on the default 16-bit/4-stage
// adder, plus a scoreboarded sweep of an 8-bit/2-stage instance.
module tb_adder_pipe_nbit;

  logic clk = 1'b0;
  logic n_rst;

  logic [15:0] a16, b16, sum16;
  logic        cin16, mode16, valid16, stall16, ovf16, vout16;

  logic [7:0]  a8, b8, sum8;
  logic        cin8, mode8, valid8, stall8, ovf8, vout8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;
    logic [15:0] expSum;
    logic        expOvf;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       o;
  } exp8_t;

  adder_pipe_nbit dut16 (
    .clk(clk), .n_rst(n_rst), .a(a16), .b(b16), .carry_in(cin16), .signed_mode(mode16),
    .valid_in(valid16), .stall(stall16), .sum(sum16), .overflow(ovf16), .valid_out(vout16)
  );

  adder_pipe_nbit #(.NUM_BITS(8), .NUM_STAGES(2)) dut8 (
    .clk(clk), .n_rst(n_rst), .a(a8), .b(b8), .carry_in(cin8), .signed_mode(mode8),
    .valid_in(valid8), .stall(stall8), .sum(sum8), .overflow(ovf8), .valid_out(vout8)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                               input logic imode, input logic ivalid, input logic istall);
    a16     = ia;
    b16     = ib;
    cin16   = icin;
    mode16  = imode;
    valid16 = ivalid;
    stall16 = istall;
  endtask

  // Data is only compared when a valid result is expected or when fullCompare demands it (reset).
  task automatic checkOutput(input string name, input logic [15:0] eSum, input logic eOvf,
                             input logic eValid, input bit fullCompare);
    checks++;
    if (vout16 !== eValid) begin
      errors++;
      $display("[TB] FAIL %s valid_out: got %0b expected %0b", name, vout16, eValid);
    end
    if (eValid || fullCompare) begin
      checks++;
      if (sum16 !== eSum) begin
        errors++;
        $display("[TB] FAIL %s sum: got %h expected %h", name, sum16, eSum);
      end
      checks++;
      if (ovf16 !== eOvf) begin
        errors++;
        $display("[TB] FAIL %s overflow: got %0b expected %0b", name, ovf16, eOvf);
      end
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mc, input logic mm);
    exp8_t      r;
    logic [8:0] t;
    t   = {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
    r.s = t[7:0];
    r.o = mm ? ((ma[7] == mb[7]) && (t[7] != ma[7])) : t[8];
    return r;
  endfunction

  vec_t vecs[13];

  initial begin
    exp8_t      q[$];
    exp8_t      got;
    exp8_t      want;
    logic [14:0] v;
    int         vecIdx;
    int         issued;
    int         compared;
    int         cycles;

    vecs[0]  = '{16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[8]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'hF000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[10] = '{16'h1234, 16'h5678, 1'b0, 1'b1, 16'h68AC, 1'b0};
    vecs[11] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    vecs[12] = '{16'h4000, 16'h4000, 1'b0, 1'b1, 16'h8000, 1'b1};

    n_rst = 1'b0;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; mode8 = 1'b0; valid8 = 1'b0; stall8 = 1'b0;

    // Reset state on both instances.
    repeat (2) tick();
    checkOutput("reset16", 16'h0000, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({sum8, ovf8, vout8} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset8: got sum=%h ovf=%0b valid=%0b expected all zero", sum8, ovf8, vout8);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checkOutput("post_reset_idle", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Single transaction latency.
    applyStimulus(16'h1234, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_e1", 16'h0, 1'b0, 1'b0, 1'b0);
    for (int e = 2; e <= 5; e++) begin
      tick();
      if (e == 4) checkOutput("lat_e4", 16'h1335, 1'b0, 1'b1, 1'b0);
      else        checkOutput($sformatf("lat_e%0d", e), 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // Back-to-back vector stream: vector j appears after the 4th edge from its capture.
    for (int i = 0; i < 13 + 3; i++) begin
      if (i < 13) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode, 1'b1, 1'b0);
      else        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 3) checkOutput($sformatf("vec%0d", i - 3), vecs[i-3].expSum, vecs[i-3].expOvf, 1'b1, 1'b0);
    end
    tick();
    checkOutput("vec_tail", 16'h0, 1'b0, 1'b0, 1'b0);

    // Stall for 3 cycles while the second transaction sits in stage 2.
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'hF000, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h00FF, 16'h0F01, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) begin
      tick();
      checkOutput($sformatf("stall_hold%0d", e), 16'h0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_t0", 16'h0003, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stall_t1", 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("stall_t2", 16'h1000, 1'b0, 1'b1, 1'b0);
    for (int e = 0; e < 2; e++) begin
      tick();
      checkOutput($sformatf("stall_after%0d", e), 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // Stall while a valid result is on the outputs: it must hold, and stalled inputs never enter.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("hold_out", 16'h3333, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) begin
      tick();
      checkOutput($sformatf("hold_stall%0d", e), 16'h3333, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      tick();
      checkOutput($sformatf("hold_drain%0d", e), 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-flight with a valid result on the outputs.
    applyStimulus(16'h5555, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_pre", 16'h6666, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("rst_async", 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(16'h0004, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_held", 16'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 6; e++) begin
      tick();
      checkOutput($sformatf("rst_after%0d", e), 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // 8-bit/2-stage sweep with random stalls and bubbles against a queue of expected results.
    vecIdx = 0; issued = 0; compared = 0; cycles = 0;
    while (((vecIdx < 32768) || (q.size() != 0)) && (cycles < 40000)) begin
      stall8 = ($urandom_range(0, 15) == 0);
      valid8 = (vecIdx < 32768) && ($urandom_range(0, 15) != 0);
      v      = vecIdx[14:0];
      a8     = v[7:0];
      b8     = {v[14:8], v[3]};
      cin8   = v[1] ^ v[12];
      mode8  = v[2] ^ v[10];
      tick();
      cycles++;
      if (!stall8) begin
        if (vout8) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sweep_extra: got valid_out=1 with sum=%h expected no result", sum8);
          end else begin
            want = q.pop_front();
            compared++;
            got.s = sum8;
            got.o = ovf8;
            if (got !== want) begin
              errors++;
              $display("[TB] FAIL sweep result #%0d: got sum=%h ovf=%0b expected sum=%h ovf=%0b",
                       compared, got.s, got.o, want.s, want.o);
            end
          end
        end
        if (valid8) begin
          q.push_back(model8(a8, b8, cin8, mode8));
          vecIdx++;
          issued++;
        end
      end
    end
    valid8 = 1'b0;
    stall8 = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (vout8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_drain%0d valid_out: got %0b expected 0", e, vout8);
      end
    end
    checks++;
    if ((compared != 32768) || (issued != 32768) || (q.size() != 0)) begin
      errors++;
      $display("[TB] FAIL sweep_count: got issued=%0d compared=%0d pending=%0d expected 32768/32768/0",
               issued, compared, q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
